// File: rtl/ebpf_fetch_unit.sv
// Instruction fetch stage for the eBPF CPU: reads 64-bit words at a fixed memory latency,
// assembles two-slot LDDW instructions and presents the decoded fields to decode over valid/ready.
module ebpf_fetch_unit #(
   parameter int PGM_ADDR_W = 12,
   parameter int MEM_LAT    = 1,
   parameter int CNT_W      = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [PGM_ADDR_W-1:0] start_pc_i,
   output logic                  mem_rd_o,
   output logic [PGM_ADDR_W-1:0] mem_addr_o,
   input  logic [63:0]           mem_rdata_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [PGM_ADDR_W-1:0] out_pc_o,
   output logic [7:0]            out_opcode_o,
   output logic [3:0]            out_src_o,
   output logic [3:0]            out_dst_o,
   output logic [15:0]           out_offset_o,
   output logic [31:0]           out_imm_o,
   output logic [31:0]           out_imm_hi_o,
   input  logic                  redirect_i,
   input  logic [PGM_ADDR_W-1:0] redirect_pc_i,
   output logic                  halted_o,
   output logic                  error_o,
   output logic [CNT_W-1:0]      insn_count_o
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_FETCH2  = 3'd3;
   localparam logic [2:0] S_WAIT2   = 3'd4;
   localparam logic [2:0] S_PRESENT = 3'd5;
   localparam logic [2:0] S_HALT    = 3'd6;

   localparam logic [7:0]            OP_LDDW  = 8'h18;
   localparam logic [7:0]            OP_EXIT  = 8'h95;
   localparam logic [PGM_ADDR_W-1:0] PC_LAST  = '1;
   localparam logic [1:0]            LAT_LAST = 2'(MEM_LAT - 1);

   logic [2:0]            state_q, state_d;
   logic [PGM_ADDR_W-1:0] pc_q, pc_d;
   logic [1:0]            lat_q, lat_d;
   logic [63:0]           word_q, word_d;
   logic [31:0]           imm_hi_q, imm_hi_d;
   logic                  halted_q, halted_d;
   logic                  error_q, error_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic                  is_lddw;
   logic                  data_here;
   logic                  redirect_ok;
   logic [PGM_ADDR_W:0]   pc_next;

   assign is_lddw     = (word_q[63:56] == OP_LDDW);
   assign data_here   = (lat_q == LAT_LAST);
   assign redirect_ok = redirect_i && (state_q != S_IDLE) && (state_q != S_HALT);
   // Extra bit lets the end-of-memory check see a step past the last word instead of wrapping.
   assign pc_next     = {1'b0, pc_q} + (is_lddw ? (PGM_ADDR_W+1)'(2) : (PGM_ADDR_W+1)'(1));

   assign mem_rd_o     = (state_q == S_FETCH) || (state_q == S_FETCH2);
   assign mem_addr_o   = (state_q == S_FETCH)  ? pc_q :
                         (state_q == S_FETCH2) ? pc_q + PGM_ADDR_W'(1) : '0;
   assign out_valid_o  = (state_q == S_PRESENT);
   assign out_pc_o     = pc_q;
   assign out_opcode_o = word_q[63:56];
   assign out_src_o    = word_q[55:52];
   assign out_dst_o    = word_q[51:48];
   assign out_offset_o = word_q[47:32];
   assign out_imm_o    = word_q[31:0];
   assign out_imm_hi_o = imm_hi_q;
   assign halted_o     = halted_q;
   assign error_o      = error_q;
   assign insn_count_o = cnt_q;

   always_comb begin
      // NOTE: every next-state signal is defaulted first so no path through the case infers a latch.
      state_d  = state_q;
      pc_d     = pc_q;
      lat_d    = lat_q;
      word_d   = word_q;
      imm_hi_d = imm_hi_q;
      halted_d = halted_q;
      error_d  = error_q;
      cnt_d    = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               pc_d     = start_pc_i;
               cnt_d    = '0;
               error_d  = 1'b0;
               halted_d = 1'b0;
               state_d  = S_FETCH;
            end
         end
         S_FETCH: begin
            lat_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (data_here) begin
               lat_d  = '0;
               word_d = mem_rdata_i;
               if (mem_rdata_i[63:56] != OP_LDDW) begin
                  imm_hi_d = '0;
                  state_d  = S_PRESENT;
               end else if (pc_q == PC_LAST) begin
                  error_d  = 1'b1;
                  halted_d = 1'b1;
                  state_d  = S_HALT;
               end else begin
                  state_d  = S_FETCH2;
               end
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         S_FETCH2: begin
            lat_d   = '0;
            state_d = S_WAIT2;
         end
         S_WAIT2: begin
            if (data_here) begin
               lat_d    = '0;
               imm_hi_d = mem_rdata_i[31:0];
               state_d  = S_PRESENT;
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         S_PRESENT: begin
            if (out_ready_i) begin
               if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
               if (word_q[63:56] == OP_EXIT) begin
                  halted_d = 1'b1;
                  state_d  = S_HALT;
               end else if (pc_next > {1'b0, PC_LAST}) begin
                  error_d  = 1'b1;
                  halted_d = 1'b1;
                  state_d  = S_HALT;
               end else begin
                  pc_d    = pc_next[PGM_ADDR_W-1:0];
                  state_d = S_FETCH;
               end
            end
         end
         default: ;
      endcase

      // A taken branch overrides everything above, including a same-cycle accept.
      if (redirect_ok) begin
         state_d  = S_FETCH;
         pc_d     = redirect_pc_i;
         lat_d    = '0;
         word_d   = '0;
         imm_hi_d = '0;
         halted_d = halted_q;
         error_d  = error_q;
         cnt_d    = cnt_q;
      end
   end

   // NOTE: registers update with non-blocking assignments only; all decisions live in the block above.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         lat_q    <= '0;
         word_q   <= '0;
         imm_hi_q <= '0;
         halted_q <= 1'b0;
         error_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         lat_q    <= lat_d;
         word_q   <= word_d;
         imm_hi_q <= imm_hi_d;
         halted_q <= halted_d;
         error_q  <= error_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_ebpf_fetch_unit.sv
// Directed bench for ebpf_fetch_unit: one instance at MEM_LAT=1 and one at MEM_LAT=3 share stimulus,
// each backed by its own fixed-latency memory model over a common program image.
`timescale 1ns/1ps
module tb_ebpf_fetch_unit;

   localparam logic [63:0] POISON = 64'h18FF_FFFF_BADB_AD00;
   localparam logic [63:0] W_EXIT = 64'h9500_0000_0000_0000;
   localparam logic [63:0] W_MOV  = 64'hB701_0000_0000_0005;
   localparam logic [63:0] W_ADD  = 64'h0701_0000_0000_0003;
   localparam logic [63:0] W_LDDW = 64'h1801_0000_DEAD_BEEF;
   localparam logic [63:0] W_HI   = 64'h0000_0000_CAFE_F00D;
   localparam logic [63:0] W_JUNK = 64'h0000_0000_1111_1111;

   typedef struct packed {
      logic        mem_rd;
      logic [11:0] mem_addr;
      logic        out_valid;
      logic [11:0] out_pc;
      logic [7:0]  opcode;
      logic [3:0]  src;
      logic [3:0]  dst;
      logic [15:0] offset;
      logic [31:0] imm;
      logic [31:0] imm_hi;
      logic        halted;
      logic        error;
      logic [31:0] cnt;
   } obs_t;

   typedef struct {
      bit          sel3;
      logic [11:0] pc;
      logic [63:0] w0;
      logic [63:0] w1;
      int          lat;
      bit          present;
      logic [7:0]  opc;
      logic [3:0]  src;
      logic [3:0]  dst;
      logic [15:0] off;
      logic [31:0] imm;
      logic [31:0] hi;
      bit          halt;
      bit          err;
      logic [11:0] nxt;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, start, out_ready, redirect;
   logic [11:0] start_pc, redirect_pc;
   bit          sel3;
   int          n_vec = 0;
   int          n_bad = 0;

   logic [63:0] mem [0:4095];
   logic [63:0] p1;
   logic [63:0] p3 [0:2];

   wire        a_rd, a_valid, a_halt, a_err, b_rd, b_valid, b_halt, b_err;
   wire [11:0] a_addr, a_pc, b_addr, b_pc;
   wire [7:0]  a_opc, b_opc;
   wire [3:0]  a_src, a_dst, b_src, b_dst;
   wire [15:0] a_off, b_off;
   wire [31:0] a_imm, a_hi, a_cnt, b_imm, b_hi, b_cnt;

   obs_t o1, o3, o;
   assign o1 = {a_rd, a_addr, a_valid, a_pc, a_opc, a_src, a_dst, a_off, a_imm, a_hi, a_halt, a_err, a_cnt};
   assign o3 = {b_rd, b_addr, b_valid, b_pc, b_opc, b_src, b_dst, b_off, b_imm, b_hi, b_halt, b_err, b_cnt};
   assign o  = sel3 ? o3 : o1;

   always #5 clk = ~clk;

   // Read data appears exactly MEM_LAT cycles after the strobe; idle cycles return a poison LDDW word.
   always @(posedge clk) p1 <= a_rd ? mem[a_addr] : POISON;
   always @(posedge clk) begin
      p3[0] <= b_rd ? mem[b_addr] : POISON;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end

   ebpf_fetch_unit #(.PGM_ADDR_W(12), .MEM_LAT(1), .CNT_W(32)) dut1 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .start_pc_i(start_pc),
      .mem_rd_o(a_rd), .mem_addr_o(a_addr), .mem_rdata_i(p1),
      .out_valid_o(a_valid), .out_ready_i(out_ready), .out_pc_o(a_pc),
      .out_opcode_o(a_opc), .out_src_o(a_src), .out_dst_o(a_dst), .out_offset_o(a_off),
      .out_imm_o(a_imm), .out_imm_hi_o(a_hi), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .halted_o(a_halt), .error_o(a_err), .insn_count_o(a_cnt));

   ebpf_fetch_unit #(.PGM_ADDR_W(12), .MEM_LAT(3), .CNT_W(32)) dut3 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .start_pc_i(start_pc),
      .mem_rd_o(b_rd), .mem_addr_o(b_addr), .mem_rdata_i(p3[2]),
      .out_valid_o(b_valid), .out_ready_i(out_ready), .out_pc_o(b_pc),
      .out_opcode_o(b_opc), .out_src_o(b_src), .out_dst_o(b_dst), .out_offset_o(b_off),
      .out_imm_o(b_imm), .out_imm_hi_o(b_hi), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .halted_o(b_halt), .error_o(b_err), .insn_count_o(b_cnt));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; out_ready = 1'b0; redirect = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   // Leaves the bench sampling the FETCH cycle of the started unit.
   task automatic start_at(input logic [11:0] pc, input string tag);
      start_pc = pc; start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_fetch"}, {o.mem_rd, o.mem_addr}, {1'b1, pc});
   endtask

   task automatic wait_valid(output int c);
      c = 0;
      while (!o.out_valid && !o.halted && c < 40) begin
         tick();
         c++;
      end
   endtask

   task automatic accept();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   vec_t        vt [12];
   vec_t        v;
   int          c;
   int          vc [$];
   logic [11:0] vp [$];
   logic        rd;

   initial begin
      rst = 1'b1; start = 1'b0; out_ready = 1'b0; redirect = 1'b0;
      start_pc = '0; redirect_pc = '0; sel3 = 1'b0;
      for (int i = 0; i < 4096; i++) mem[i] = W_EXIT;

      //           sel pc      w0                      w1      lat pr opc    src   dst   off       imm           hi            hlt err nxt
      vt[0]  = '{1'b0, 12'h000, W_MOV,                 W_JUNK, 2, 1'b1, 8'hB7, 4'h0, 4'h1, 16'h0000, 32'h0000_0005, 32'h0,         1'b0, 1'b0, 12'h001};
      vt[1]  = '{1'b0, 12'h001, W_ADD,                 W_JUNK, 2, 1'b1, 8'h07, 4'h0, 4'h1, 16'h0000, 32'h0000_0003, 32'h0,         1'b0, 1'b0, 12'h002};
      vt[2]  = '{1'b0, 12'h002, W_EXIT,                W_JUNK, 2, 1'b1, 8'h95, 4'h0, 4'h0, 16'h0000, 32'h0000_0000, 32'h0,         1'b1, 1'b0, 12'h000};
      vt[3]  = '{1'b0, 12'h004, W_LDDW,                W_HI,   4, 1'b1, 8'h18, 4'h0, 4'h1, 16'h0000, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1'b0, 12'h006};
      vt[4]  = '{1'b0, 12'hFFF, W_MOV,                 W_JUNK, 2, 1'b1, 8'hB7, 4'h0, 4'h1, 16'h0000, 32'h0000_0005, 32'h0,         1'b1, 1'b1, 12'h000};
      vt[5]  = '{1'b0, 12'hFFF, W_LDDW,                W_HI,   2, 1'b0, 8'h00, 4'h0, 4'h0, 16'h0000, 32'h0,         32'h0,         1'b1, 1'b1, 12'h000};
      vt[6]  = '{1'b0, 12'hFFE, 64'h1805_0000_0000_0001, 64'h2, 4, 1'b1, 8'h18, 4'h0, 4'h5, 16'h0000, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b1, 12'h000};
      vt[7]  = '{1'b1, 12'h000, W_MOV,                 W_JUNK, 4, 1'b1, 8'hB7, 4'h0, 4'h1, 16'h0000, 32'h0000_0005, 32'h0,         1'b0, 1'b0, 12'h001};
      vt[8]  = '{1'b1, 12'h004, W_LDDW,                W_HI,   8, 1'b1, 8'h18, 4'h0, 4'h1, 16'h0000, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1'b0, 12'h006};
      vt[9]  = '{1'b1, 12'h010, 64'h6123_0010_0000_0007, W_JUNK, 4, 1'b1, 8'h61, 4'h2, 4'h3, 16'h0010, 32'h0000_0007, 32'h0,     1'b0, 1'b0, 12'h011};
      vt[10] = '{1'b1, 12'hFFF, W_MOV,                 W_JUNK, 4, 1'b1, 8'hB7, 4'h0, 4'h1, 16'h0000, 32'h0000_0005, 32'h0,         1'b1, 1'b1, 12'h000};
      vt[11] = '{1'b1, 12'hFFF, W_LDDW,                W_HI,   4, 1'b0, 8'h00, 4'h0, 4'h0, 16'h0000, 32'h0,         32'h0,         1'b1, 1'b1, 12'h000};

      // Reset state, with a start pulse held during reset.
      start = 1'b1; start_pc = 12'h005;
      tick(); tick();
      check("rst_ctl1", {o1.mem_rd, o1.mem_addr, o1.out_valid, o1.out_pc, o1.halted, o1.error}, 64'h0);
      check("rst_fields1", {o1.opcode, o1.src, o1.dst, o1.offset, o1.imm}, 64'h0);
      check("rst_hi_cnt1", {o1.imm_hi, o1.cnt}, 64'h0);
      check("rst_ctl3", {o3.mem_rd, o3.out_valid, o3.halted, o3.error, o3.cnt}, 64'h0);
      rst = 1'b0; start = 1'b0;
      tick();
      check("rst_idle", {o1.mem_rd, o1.out_valid, o1.out_pc}, 64'h0);

      for (int i = 0; i < 12; i++) begin
         v = vt[i];
         do_reset();
         sel3 = v.sel3;
         mem[v.pc] = v.w0;
         if (v.pc != 12'hFFF) mem[v.pc + 12'd1] = v.w1;
         start_at(v.pc, $sformatf("v%0d", i));
         wait_valid(c);
         check($sformatf("v%0d_lat", i), 64'(c), 64'(v.lat));
         if (v.present) begin
            check($sformatf("v%0d_valid", i), {o.out_valid, o.halted}, 2'b10);
            check($sformatf("v%0d_fields", i), {o.opcode, o.src, o.dst, o.offset, o.imm},
                  {v.opc, v.src, v.dst, v.off, v.imm});
            check($sformatf("v%0d_hi_pc", i), {o.imm_hi, o.out_pc}, {v.hi, v.pc});
            accept();
            check($sformatf("v%0d_count", i), o.cnt, 64'd1);
            if (v.halt) begin
               check($sformatf("v%0d_halt", i), {o.halted, o.error}, {1'b1, v.err});
               rd = 1'b0;
               repeat (3) begin
                  tick();
                  rd = rd | o.mem_rd;
               end
               check($sformatf("v%0d_quiet", i), {rd, o.out_valid, o.halted}, 3'b001);
            end else begin
               check($sformatf("v%0d_next", i), {o.halted, o.mem_rd, o.mem_addr}, {1'b0, 1'b1, v.nxt});
            end
         end else begin
            check($sformatf("v%0d_nopres", i), {o.out_valid, o.halted, o.error, o.cnt}, {3'b011, 32'd0});
         end
      end

      // Straight-line program, decode always ready: presentations 3 cycles apart.
      do_reset();
      sel3 = 1'b0;
      mem[0] = W_MOV; mem[1] = W_ADD; mem[2] = W_EXIT;
      out_ready = 1'b1;
      start_at(12'h000, "seq");
      rd = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (o.out_valid) begin
            vc.push_back(k);
            vp.push_back(o.out_pc);
         end
         if (o.halted && o.mem_rd) rd = 1'b1;
         tick();
      end
      out_ready = 1'b0;
      check("seq_count_pres", 64'(vc.size()), 64'd3);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("seq_cycle%0d", k), 64'((k < vc.size()) ? vc[k] : -1), 64'(2 + 3 * k));
         check($sformatf("seq_pc%0d", k), (k < vp.size()) ? 64'(vp[k]) : 64'hFFFF, 64'(k));
      end
      check("seq_end", {o.halted, o.error, rd, o.cnt}, {3'b100, 32'd3});

      // Backpressure: fields hold and no read is issued while decode stalls.
      do_reset();
      sel3 = 1'b0;
      mem[0] = W_MOV; mem[1] = W_ADD;
      start_at(12'h000, "bp");
      wait_valid(c);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp_fields%0d", k), {o.opcode, o.src, o.dst, o.offset, o.imm}, W_MOV);
         check($sformatf("bp_ctl%0d", k), {o.mem_rd, o.out_valid, o.out_pc, o.cnt}, {2'b01, 12'h000, 32'd0});
         tick();
      end
      accept();
      check("bp_accept", {o.cnt, o.mem_rd, o.mem_addr}, {32'd1, 1'b1, 12'h001});

      // Redirect during WAIT at MEM_LAT=3: the stale word must never surface.
      do_reset();
      sel3 = 1'b1;
      mem[0] = W_MOV; mem[12'h020] = W_ADD;
      start_at(12'h000, "rdw");
      tick();
      redirect = 1'b1; redirect_pc = 12'h020;
      tick();
      redirect = 1'b0;
      check("rdw_refetch", {o.mem_rd, o.mem_addr, o.out_valid}, {1'b1, 12'h020, 1'b0});
      wait_valid(c);
      check("rdw_lat", 64'(c), 64'd4);
      check("rdw_word", {o.out_pc, o.opcode, o.imm}, {12'h020, 8'h07, 32'd3});
      accept();
      check("rdw_next", {o.cnt, o.mem_rd, o.mem_addr}, {32'd1, 1'b1, 12'h021});

      // Redirect coincident with accept, including on an EXIT.
      do_reset();
      sel3 = 1'b0;
      mem[0] = W_MOV; mem[12'h030] = W_EXIT;
      start_at(12'h000, "rda");
      wait_valid(c);
      out_ready = 1'b1; redirect = 1'b1; redirect_pc = 12'h030;
      tick();
      out_ready = 1'b0; redirect = 1'b0;
      check("rda_nocount", {o.cnt, o.mem_rd, o.mem_addr}, {32'd0, 1'b1, 12'h030});
      wait_valid(c);
      check("rda_exitword", {o.out_valid, o.out_pc, o.opcode}, {1'b1, 12'h030, 8'h95});
      out_ready = 1'b1; redirect = 1'b1; redirect_pc = 12'h040;
      tick();
      out_ready = 1'b0; redirect = 1'b0;
      check("rda_exit_skip", {o.halted, o.error, o.cnt, o.mem_rd, o.mem_addr}, {2'b00, 32'd0, 1'b1, 12'h040});
      wait_valid(c);
      accept();
      check("rda_halt", {o.halted, o.error, o.cnt}, {2'b10, 32'd1});
      redirect = 1'b1; redirect_pc = 12'h050;
      tick();
      redirect = 1'b0;
      tick();
      check("halt_redir", {o.mem_rd, o.out_valid, o.halted, o.out_pc}, {3'b001, 12'h040});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
